// File: rtl/spi_slave_param.sv
// Parametrised SPI slave clocked only by sclk: configurable width, bit order,
// CPOL/CPHA, multi-word frames with per-word TX reload and completion toggles.
module spi_slave_param #(
  parameter int DATA_W    = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0,
  parameter int CNT_W     = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_tgl,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_tgl,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BIT_W = $clog2(DATA_W);

  // Sample edge is always the rising edge of samp_clk; launch edge is its falling edge.
  logic samp_clk;
  logic frame_clr;
  assign samp_clk  = sclk ^ (CPOL != 0) ^ (CPHA != 0);
  assign frame_clr = rst | ss;

  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_tgl_q, rx_tgl_d;
  logic              last_bit;
  logic              word_done;

  assign last_bit  = (bit_cnt_q == BIT_W'(DATA_W - 1));
  assign word_done = last_bit & ~ss;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    rx_shift_d = (LSB_FIRST != 0) ? {mosi, rx_shift_q[DATA_W-1:1]}
                                  : {rx_shift_q[DATA_W-2:0], mosi};
    bit_cnt_d  = bit_cnt_q + BIT_W'(1);
    word_cnt_d = word_cnt_q;
    rx_data_d  = rx_data_q;
    rx_tgl_d   = rx_tgl_q;
    if (last_bit) begin
      bit_cnt_d  = '0;
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
    if (word_done) begin
      rx_data_d = rx_shift_d;
      rx_tgl_d  = ~rx_tgl_q;
    end
  end

  // Frame state is cleared asynchronously whenever the slave is deselected.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge samp_clk or posedge frame_clr) begin
    if (frame_clr) begin
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      rx_shift_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_ff @(posedge samp_clk or posedge rst) begin
    if (rst) begin
      rx_data_q <= '0;
      rx_tgl_q  <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rx_tgl_q  <= rx_tgl_d;
    end
  end

  // TX side: tx_shift holds the captured word; miso_q holds the bit on the wire.
  logic [DATA_W-1:0] tx_shift_q;
  logic              tx_tgl_q;
  logic              miso_q;
  logic              miso_d;
  logic              tx_first_bit;
  logic [BIT_W-1:0]  tx_bit_sel;

  assign tx_first_bit = (LSB_FIRST != 0) ? tx_data[0] : tx_data[DATA_W-1];
  assign tx_bit_sel   = (LSB_FIRST != 0) ? bit_cnt_q : (BIT_W'(DATA_W - 1) - bit_cnt_q);

  if (CPHA == 0) begin : g_cpha0
    always_ff @(posedge samp_clk or posedge frame_clr) begin
      if (frame_clr)           tx_shift_q <= '0;
      else if (bit_cnt_q == '0) tx_shift_q <= tx_data;
    end

    always_ff @(posedge samp_clk or posedge rst) begin
      if (rst)                           tx_tgl_q <= 1'b0;
      else if (!ss && bit_cnt_q == '0)   tx_tgl_q <= ~tx_tgl_q;
    end

    always_ff @(negedge samp_clk or posedge frame_clr) begin
      if (frame_clr) miso_q <= 1'b0;
      else           miso_q <= tx_shift_q[tx_bit_sel];
    end

    // First bit of each word comes straight from tx_data before any launch edge exists.
    assign miso_d = (bit_cnt_q == '0) ? tx_first_bit : miso_q;
  end else begin : g_cpha1
    always_ff @(negedge samp_clk or posedge frame_clr) begin
      if (frame_clr) begin
        tx_shift_q <= '0;
        miso_q     <= 1'b0;
      end else if (bit_cnt_q == '0) begin
        tx_shift_q <= tx_data;
        miso_q     <= tx_first_bit;
      end else begin
        miso_q     <= tx_shift_q[tx_bit_sel];
      end
    end

    always_ff @(negedge samp_clk or posedge rst) begin
      if (rst)                           tx_tgl_q <= 1'b0;
      else if (!ss && bit_cnt_q == '0)   tx_tgl_q <= ~tx_tgl_q;
    end

    assign miso_d = miso_q;
  end

  assign miso     = (!ss && !rst) ? miso_d : 1'b0;
  assign miso_oe  = ~ss;
  assign tx_tgl   = tx_tgl_q;
  assign rx_data  = rx_data_q;
  assign rx_tgl   = rx_tgl_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: three configurations driven by a behavioural SPI
// master, checked against a word-level model of frames, toggles and counters.
module tb_spi_slave_param;

  localparam int W_OF    [3] = '{8, 16, 8};
  localparam int CPOL_OF [3] = '{0, 1, 0};
  localparam int CPHA_OF [3] = '{0, 1, 0};
  localparam int LSB_OF  [3] = '{0, 1, 0};
  localparam int CNT_OF  [3] = '{8, 8, 2};

  logic [2:0]  sclk_v, rst_v, ss_v, mosi_v;
  logic [2:0]  miso_v, miso_oe_v, tx_tgl_v, rx_tgl_v;
  logic [31:0] tx_d [3];
  logic [7:0]  rx0, rx2, wc0, wc1;
  logic [15:0] rx1;
  logic [1:0]  wc2;

  int total = 0;
  int bad   = 0;

  // Word-level reference model
  int          m_rx    [3];
  int          m_tx    [3];
  int          m_words [3];
  logic [31:0] m_rxd   [3];

  spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .CNT_W(8)) u_d0 (
    .sclk(sclk_v[0]), .rst(rst_v[0]), .ss(ss_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .miso_oe(miso_oe_v[0]), .tx_data(tx_d[0][7:0]),
    .tx_tgl(tx_tgl_v[0]), .rx_data(rx0), .rx_tgl(rx_tgl_v[0]), .word_cnt(wc0));

  spi_slave_param #(.DATA_W(16), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .CNT_W(8)) u_d1 (
    .sclk(sclk_v[1]), .rst(rst_v[1]), .ss(ss_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1]), .miso_oe(miso_oe_v[1]), .tx_data(tx_d[1][15:0]),
    .tx_tgl(tx_tgl_v[1]), .rx_data(rx1), .rx_tgl(rx_tgl_v[1]), .word_cnt(wc1));

  spi_slave_param #(.DATA_W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .CNT_W(2)) u_d2 (
    .sclk(sclk_v[2]), .rst(rst_v[2]), .ss(ss_v[2]), .mosi(mosi_v[2]),
    .miso(miso_v[2]), .miso_oe(miso_oe_v[2]), .tx_data(tx_d[2][7:0]),
    .tx_tgl(tx_tgl_v[2]), .rx_data(rx2), .rx_tgl(rx_tgl_v[2]), .word_cnt(wc2));

  function automatic logic [31:0] mask(int id);
    return (32'h1 << W_OF[id]) - 32'h1;
  endfunction

  function automatic logic [31:0] rx_of(int id);
    case (id)
      0:       return 32'(rx0);
      1:       return 32'(rx1);
      default: return 32'(rx2);
    endcase
  endfunction

  function automatic logic [31:0] wc_of(int id);
    case (id)
      0:       return 32'(wc0);
      1:       return 32'(wc1);
      default: return 32'(wc2);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(int id, string what);
    check($sformatf("d%0d_%s_rx_data", id, what), rx_of(id), m_rxd[id]);
    check($sformatf("d%0d_%s_rx_tgl", id, what), 32'(rx_tgl_v[id]), 32'(m_rx[id] % 2));
    check($sformatf("d%0d_%s_tx_tgl", id, what), 32'(tx_tgl_v[id]), 32'(m_tx[id] % 2));
    check($sformatf("d%0d_%s_word_cnt", id, what), wc_of(id),
          32'(m_words[id] % (1 << CNT_OF[id])));
  endtask

  task automatic model_reset(int id);
    m_rx[id] = 0;
    m_tx[id] = 0;
    m_words[id] = 0;
    m_rxd[id] = '0;
  endtask

  task automatic start_frame(int id);
    ss_v[id] = 1'b0;
    #5;
    check($sformatf("d%0d_oe_on", id), 32'(miso_oe_v[id]), 32'd1);
  endtask

  task automatic end_frame(int id);
    #5;
    ss_v[id] = 1'b1;
    m_words[id] = 0;
    #5;
    check($sformatf("d%0d_oe_off", id), 32'(miso_oe_v[id]), 32'd0);
    check($sformatf("d%0d_miso_idle", id), 32'(miso_v[id]), 32'd0);
  endtask

  // Master shifts nbits of mo out (in the configured order) and collects miso.
  task automatic xfer(int id, logic [31:0] mo, logic [31:0] tx, int nbits,
                      output logic [31:0] got);
    got = '0;
    tx_d[id] = tx & mask(id);
    for (int i = 0; i < nbits; i++) begin
      int pos;
      pos = (LSB_OF[id] != 0) ? i : W_OF[id] - 1 - i;
      if (CPHA_OF[id] == 0) begin
        mosi_v[id] = mo[pos];
        #4 got[pos] = miso_v[id];
        #1 sclk_v[id] = ~sclk_v[id];
        #5 sclk_v[id] = ~sclk_v[id];
      end else begin
        sclk_v[id] = ~sclk_v[id];
        mosi_v[id] = mo[pos];
        #4 got[pos] = miso_v[id];
        #1 sclk_v[id] = ~sclk_v[id];
        #5;
      end
    end
    #2;
    if (nbits > 0) m_tx[id]++;
    if (nbits == W_OF[id]) begin
      m_rx[id]++;
      m_words[id]++;
      m_rxd[id] = mo & mask(id);
    end
  endtask

  task automatic word(int id, logic [31:0] mo, logic [31:0] tx);
    logic [31:0] got;
    xfer(id, mo, tx, W_OF[id], got);
    check($sformatf("d%0d_miso_word", id), got, tx & mask(id));
    check_state(id, "word");
  endtask

  initial begin
    logic [31:0] got;
    int nw;

    for (int id = 0; id < 3; id++) begin
      sclk_v[id] = (CPOL_OF[id] != 0);
      ss_v[id]   = 1'b1;
      mosi_v[id] = 1'b0;
      rst_v[id]  = 1'b1;
      tx_d[id]   = '0;
      model_reset(id);
    end
    #10;
    for (int id = 0; id < 3; id++) begin
      check_state(id, "reset");
      check($sformatf("d%0d_reset_miso", id), 32'(miso_v[id]), 32'd0);
    end
    rst_v = 3'b000;
    #10;

    // Mode 0, MSB first, single word
    start_frame(0);
    word(0, 32'h3C, 32'hA5);
    end_frame(0);

    // Mode 3, 16-bit, LSB first
    start_frame(1);
    word(1, 32'hBEEF, 32'h1234);
    end_frame(1);

    // Three-word frame with per-word TX reload
    start_frame(0);
    word(0, 32'h01, 32'h11);
    word(0, 32'h02, 32'h22);
    word(0, 32'h03, 32'h33);
    end_frame(0);

    // Aborted word followed by a clean word
    start_frame(0);
    xfer(0, 32'hF0, 32'h5A, 5, got);
    check_state(0, "partial");
    end_frame(0);
    start_frame(0);
    word(0, 32'h81, 32'hC3);
    end_frame(0);

    // sclk activity while deselected must not disturb anything
    for (int k = 0; k < 6; k++) begin
      #5 sclk_v[0] = ~sclk_v[0];
    end
    #5;
    check_state(0, "idle_edges");
    check("d0_idle_miso", 32'(miso_v[0]), 32'd0);

    // Reset pulsed mid-word, then a word in the same selected period
    start_frame(0);
    xfer(0, 32'hAA, 32'h0F, 4, got);
    rst_v[0] = 1'b1;
    model_reset(0);
    #3;
    check_state(0, "mid_rst");
    check("d0_mid_rst_miso", 32'(miso_v[0]), 32'd0);
    rst_v[0] = 1'b0;
    #5;
    word(0, 32'h55, 32'h96);
    end_frame(0);

    // Narrow word counter wraps: 1,2,3,0,1
    start_frame(2);
    for (int k = 0; k < 5; k++) word(2, $urandom & 32'hFF, $urandom & 32'hFF);
    end_frame(2);

    // Randomised frames on every configuration
    for (int r = 0; r < 4; r++) begin
      for (int id = 0; id < 3; id++) begin
        nw = $urandom_range(1, 5);
        start_frame(id);
        for (int k = 0; k < nw; k++) word(id, $urandom, $urandom);
        if ($urandom_range(0, 1) == 1) begin
          xfer(id, $urandom, $urandom, $urandom_range(1, W_OF[id] - 1), got);
          check_state(id, "rand_partial");
        end
        end_frame(id);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
